// File: rtl/const_load_sequencer.sv
// const_load_sequencer: materialises a 64-bit constant into a register as a MOVZ/MOVK write sequence
module const_load_sequencer #(
    parameter bit         SKIP_ZERO = 1'b1,
    parameter logic [4:0] ZERO_REG  = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqvalid,
    output logic        reqready,
    input  logic [63:0] reqdata,
    input  logic [4:0]  reqrd,
    output logic [2:0]  extctrl,
    output logic [25:0] imm26,
    input  logic [63:0] busimm,
    output logic        wren,
    output logic [4:0]  wraddr,
    output logic [63:0] wrdata,
    output logic        busy,
    output logic        done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    logic [1:0]  state;
    logic [63:0] data;
    logic [63:0] acc;
    logic [4:0]  rd;
    logic [1:0]  hw;
    logic [3:0]  mask;
    logic        first;
    logic [3:0]  req_mask;
    logic [3:0]  rest;
    logic [15:0] half;
    logic        issue;
    logic        last;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    // Halfword selection at accept, and per-op extender drive and write data
    always_comb begin
        req_mask = !SKIP_ZERO ? 4'b1111 :
                   (reqdata == 64'd0) ? 4'b0001 :
                   {|reqdata[63:48], |reqdata[47:32], |reqdata[31:16], |reqdata[15:0]};
        issue    = state == ISSUE;
        rest     = mask & ~(4'b0001 << hw);
        last     = rest == 4'b0000;
        half     = data[{hw, 4'b0000} +: 16];
        extctrl  = {1'b1, issue ? hw : 2'b00};
        imm26    = issue ? {3'b000, hw, half, 5'b00000} : 26'd0;
        wren     = issue;
        wraddr   = issue ? rd : 5'd0;
        wrdata   = !issue ? 64'd0 : first ? busimm : (acc | busimm);
        busy     = issue;
        done     = (issue & last) | (state == FIN);
        reqready = (state == IDLE) & ~reset;
    end

    // Request capture and one-op-per-cycle sequencing through the masked halfwords
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            data  <= 64'd0;
            acc   <= 64'd0;
            rd    <= 5'd0;
            hw    <= 2'd0;
            mask  <= 4'd0;
            first <= 1'b0;
        end else begin
            case (state)
                IDLE: if (reqvalid) begin
                    data  <= reqdata;
                    rd    <= reqrd;
                    mask  <= req_mask;
                    hw    <= lowest(req_mask);
                    acc   <= 64'd0;
                    first <= 1'b1;
                    state <= (reqrd == ZERO_REG) ? FIN : ISSUE;
                end
                ISSUE: begin
                    acc   <= wrdata;
                    first <= 1'b0;
                    mask  <= rest;
                    hw    <= lowest(rest);
                    state <= last ? IDLE : ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_const_load_sequencer.sv
// tb_const_load_sequencer: randomized and directed checks against a halfword-level reference model
module tb_const_load_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqvalid = 1'b0;
    logic        reqready;
    logic [63:0] reqdata = 64'd0;
    logic [4:0]  reqrd = 5'd0;
    logic [2:0]  extctrl;
    logic [25:0] imm26;
    logic [63:0] busimm;
    logic        wren;
    logic [4:0]  wraddr;
    logic [63:0] wrdata;
    logic        busy;
    logic        done;
    int          n_cmp = 0;
    int          n_err = 0;

    const_load_sequencer dut (
        .clk(clk), .reset(reset), .reqvalid(reqvalid), .reqready(reqready),
        .reqdata(reqdata), .reqrd(reqrd), .extctrl(extctrl), .imm26(imm26),
        .busimm(busimm), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Wide-move extender: place the 16-bit immediate at halfword Ctrl[1:0], zero elsewhere
    assign busimm = {48'd0, imm26[20:5]} << {extctrl[1:0], 4'b0000};

    // Reference: issued halfwords in ascending order with the running accumulated value
    function automatic void model(input logic [63:0] d, output int n, output logic [1:0] k_of[4],
                                  output logic [63:0] w_of[4]);
        logic [63:0] a = 64'd0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] h = d[16*k +: 16];
            if (h != 16'd0 || (d == 64'd0 && k == 0)) begin
                a = a | ({48'd0, h} << (16*k));
                k_of[n] = 2'(k);
                w_of[n] = a;
                n++;
            end
        end
    endfunction

    task automatic run_req(input logic [63:0] d, input logic [4:0] r, input string tag);
        int n;
        logic [1:0] k_of[4];
        logic [63:0] w_of[4];
        logic [100:0] got, exp;
        model(d, n, k_of, w_of);
        @(negedge clk);
        n_cmp++;
        if (reqready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_before: got %b need 1", tag, reqready);
        end
        reqvalid = 1'b1;
        reqdata = d;
        reqrd = r;
        @(posedge clk);
        #1;
        reqvalid = 1'b0;
        reqdata = {$urandom, $urandom};
        reqrd = 5'($urandom);
        if (r == 5'd31) begin
            @(negedge clk);
            n_cmp++;
            if ({wren, busy, done} !== 3'b001) begin
                n_err++;
                $display("FAIL %s xzr_c1: got wren/busy/done=%b need 001", tag, {wren, busy, done});
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                got = {wren, wraddr, extctrl, imm26, wrdata, done, busy};
                exp = {1'b1, r, 1'b1, k_of[i], 3'b000, k_of[i], d[16*k_of[i] +: 16], 5'b00000,
                       w_of[i], i == n - 1, 1'b1};
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL %s op%0d: got %h need %h", tag, i, got, exp);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({reqready, wren, done, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL %s ready_after: got rdy/wren/done/busy=%b need 1000", tag,
                     {reqready, wren, done, busy});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqvalid = 1'b1;
        reqdata = 64'hFFFF_FFFF_FFFF_FFFF;
        reqrd = 5'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({reqready, wren, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: got rdy/wren/busy/done=%b need 0000", {reqready, wren, busy, done});
        end
        reqvalid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({reqready, wren, busy, done, extctrl, imm26, wraddr, wrdata} !== {4'b1000, 3'b100, 95'd0}) begin
            n_err++;
            $display("FAIL reset_idle: got rdy=%b wren=%b busy=%b done=%b ctrl=%b imm=%h addr=%0d data=%h",
                     reqready, wren, busy, done, extctrl, imm26, wraddr, wrdata);
        end
    endtask

    task automatic test_directed();
        run_req(64'h0000_0000_0000_1234, 5'd3, "single");
        run_req(64'h1234_0000_0000_ABCD, 5'd5, "two_ops");
        run_req(64'h0, 5'd7, "zero");
        run_req(64'hFFFF_FFFF_FFFF_FFFF, 5'd30, "all_ones");
        run_req(64'h0000_8000_0000_0000, 5'd0, "top_only");
    endtask

    task automatic test_zero_reg();
        run_req(64'hDEAD_BEEF_0123_4567, 5'd31, "xzr_data");
        run_req(64'h0, 5'd31, "xzr_zero");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reqvalid = 1'b1;
        reqdata = 64'hFFFF_FFFF_FFFF_FFFF;
        reqrd = 5'd12;
        @(posedge clk);
        #1;
        reqvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wren, busy, reqready} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_mid: got wren/busy/rdy=%b need 001", {wren, busy, reqready});
        end
        run_req(64'h0000_0000_0000_0001, 5'd12, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [63:0] a = 64'h0001_0002_0003_0004;
        @(negedge clk);
        reqvalid = 1'b1;
        reqdata = a;
        reqrd = 5'd9;
        @(posedge clk);
        #1;
        reqdata = 64'h5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({wren, reqready, done, wrdata, extctrl} !== {2'b10, i == 3, a & ~(64'hFFFF_FFFF_FFFF_FFFF << (16*(i+1))),
                                                               1'b1, 2'(3 - (3 - i))}) begin
                n_err++;
                $display("FAIL b2b_c%0d: got wren=%b rdy=%b done=%b data=%h ctrl=%b", i + 1, wren, reqready,
                         done, wrdata, extctrl);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({reqready, wren} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_c5: got rdy/wren=%b need 10", {reqready, wren});
        end
        @(posedge clk);
        #1;
        reqvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wren, done, wrdata, wraddr} !== {2'b11, 64'h5, 5'd9}) begin
            n_err++;
            $display("FAIL b2b_c6: got wren=%b done=%b data=%h addr=%0d", wren, done, wrdata, wraddr);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [63:0] d = {$urandom, $urandom};
            logic [4:0] r = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 0) d[16*k +: 16] = 16'd0;
            run_req(d, r, $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_reg();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
